// File: rtl/apb_pkg.sv
// Shared APB definitions: bridge state encoding, default address map and
// peripheral slot indices used by both the bridge and the SoC top.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  // Peripheral window is BASE_HI in addr[31:14], slave index in addr[13:12]
  localparam int          DEF_SEL_LSB = 12;
  localparam int          DEF_SEL_W   = 2;
  localparam logic [17:0] DEF_BASE_HI = 18'h2FC00;

  localparam int GPIO_IDX  = 0;
  localparam int UART_IDX  = 1;
  localparam int TIMER_IDX = 2;
  localparam int SPI_IDX   = 3;

endpackage

// File: rtl/apb_rdata_mux.sv
// Combinational return-path selector: picks the addressed slave's prdata,
// pready and pslverr out of the flattened per-slave buses.
module apb_rdata_mux #(
  parameter int SEL_W = 2,
  parameter int NSLV  = 2 ** SEL_W
) (
  input  logic [SEL_W-1:0]    idx,
  input  logic [32*NSLV-1:0]  prdata,
  input  logic [NSLV-1:0]     pready,
  input  logic [NSLV-1:0]     pslverr,
  output logic [31:0]         rdata,
  output logic                ready,
  output logic                slverr
);

  always_comb begin
    rdata  = '0;
    ready  = 1'b0;
    slverr = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (idx == SEL_W'(i)) begin
        rdata  = prdata[32*i +: 32];
        ready  = pready[i];
        slverr = pslverr[i];
      end
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// APB initiator: turns single-outstanding CPU requests into APB SETUP/ACCESS
// transfers with address decode, wait states, pslverr and a wait timeout.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int                          SEL_LSB = DEF_SEL_LSB,
  parameter int                          SEL_W   = DEF_SEL_W,
  parameter logic [31-SEL_LSB-SEL_W:0]   BASE_HI = DEF_BASE_HI,
  parameter int unsigned                 TIMEOUT = 255,
  localparam int                         NSLV    = 2 ** SEL_W
) (
  input  logic                 apb_pclk,
  input  logic                 apb_prst,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [31:0]          cpu_addr,
  input  logic [31:0]          cpu_wdata,
  output logic                 cpu_ready,
  output logic                 cpu_resp_valid,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_err,
  output logic [NSLV-1:0]      apb_psel,
  output logic [31:0]          apb_paddr,
  output logic                 apb_pwrite,
  output logic                 apb_penable,
  output logic [31:0]          apb_pwdata,
  input  logic [32*NSLV-1:0]   apb_prdata,
  input  logic [NSLV-1:0]      apb_pready,
  input  logic [NSLV-1:0]      apb_pslverr
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  apb_state_e        state_q, state_d;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic              we_q;
  logic [SEL_W-1:0]  idx_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic              dec_hit;
  logic              timeout_hit;
  logic [31:0]       mux_rdata;
  logic              mux_ready;
  logic              mux_slverr;

  assign dec_hit = (cpu_addr[31:SEL_LSB+SEL_W] == BASE_HI);

  // The counter holds the number of completed ACCESS cycles, so it equals
  // TIMEOUT-1 during the last ACCESS cycle that is still allowed to wait.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  apb_rdata_mux #(
    .SEL_W (SEL_W),
    .NSLV  (NSLV)
  ) u_rdata_mux (
    .idx     (idx_q),
    .prdata  (apb_prdata),
    .pready  (apb_pready),
    .pslverr (apb_pslverr),
    .rdata   (mux_rdata),
    .ready   (mux_ready),
    .slverr  (mux_slverr)
  );

  always_ff @(posedge apb_pclk or posedge apb_prst) begin
    if (apb_prst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cpu_ready      = 1'b0;
    cpu_resp_valid = 1'b0;
    apb_psel       = '0;
    apb_penable    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cpu_ready = 1'b1;
        if (cpu_req) begin
          state_d = dec_hit ? ST_SETUP : ST_RESP;
        end
      end
      ST_SETUP: begin
        apb_psel[idx_q] = 1'b1;
        state_d         = ST_ACCESS;
      end
      ST_ACCESS: begin
        apb_psel[idx_q] = 1'b1;
        apb_penable     = 1'b1;
        if (mux_ready || timeout_hit) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        cpu_resp_valid = 1'b1;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture, wait counter and response data; a ready slave takes
  // priority over a simultaneous timeout.
  always_ff @(posedge apb_pclk or posedge apb_prst) begin
    if (apb_prst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cpu_req) begin
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            we_q    <= cpu_we;
            idx_q   <= cpu_addr[SEL_LSB +: SEL_W];
            if (!dec_hit) begin
              rdata_q <= '0;
              err_q   <= 1'b1;
            end
          end
        end
        ST_ACCESS: begin
          cnt_q <= cnt_q + 1'b1;
          if (mux_ready) begin
            rdata_q <= we_q ? 32'h0 : mux_rdata;
            err_q   <= mux_slverr;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        ST_RESP: begin
          cnt_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign apb_paddr  = addr_q;
  assign apb_pwrite = we_q;
  assign apb_pwdata = wdata_q;
  assign cpu_rdata  = rdata_q;
  assign cpu_err    = err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: four behavioural slaves, a response scoreboard
// and directed scenarios for writes, wait states, errors, miss, timeout, reset.
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int NSLV = 4;

  logic               apb_pclk;
  logic               apb_prst;
  logic               cpu_req;
  logic               cpu_we;
  logic [31:0]        cpu_addr;
  logic [31:0]        cpu_wdata;
  logic               cpu_ready;
  logic               cpu_resp_valid;
  logic [31:0]        cpu_rdata;
  logic               cpu_err;
  logic [NSLV-1:0]    apb_psel;
  logic [31:0]        apb_paddr;
  logic               apb_pwrite;
  logic               apb_penable;
  logic [31:0]        apb_pwdata;
  logic [32*NSLV-1:0] apb_prdata;
  logic [NSLV-1:0]    apb_pready;
  logic [NSLV-1:0]    apb_pslverr;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;

  logic [31:0] slv_reg [NSLV];
  int          wcnt [NSLV];
  int          wait_cfg [NSLV];
  logic        err_cfg [NSLV];
  logic        hang [NSLV];

  apb_master_bridge #(
    .TIMEOUT (4)
  ) dut (
    .apb_pclk       (apb_pclk),
    .apb_prst       (apb_prst),
    .cpu_req        (cpu_req),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_ready      (cpu_ready),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_rdata      (cpu_rdata),
    .cpu_err        (cpu_err),
    .apb_psel       (apb_psel),
    .apb_paddr      (apb_paddr),
    .apb_pwrite     (apb_pwrite),
    .apb_penable    (apb_penable),
    .apb_pwdata     (apb_pwdata),
    .apb_prdata     (apb_prdata),
    .apb_pready     (apb_pready),
    .apb_pslverr    (apb_pslverr)
  );

  initial begin
    apb_pclk = 1'b0;
    forever #5 apb_pclk = ~apb_pclk;
  end

  always @(posedge apb_pclk) cyc <= cyc + 1;

  // Behavioural slaves: GPIO has no pready, the others wait wait_cfg cycles
  always_comb begin
    apb_pready = '0;
    apb_pready[GPIO_IDX] = 1'b1;
    for (int i = 1; i < NSLV; i++)
      apb_pready[i] = !hang[i] && (wcnt[i] >= wait_cfg[i]);
  end

  always_comb begin
    for (int i = 0; i < NSLV; i++) apb_pslverr[i] = err_cfg[i];
  end

  assign apb_prdata = {slv_reg[3], slv_reg[2], slv_reg[1], slv_reg[0]};

  always @(posedge apb_pclk or posedge apb_prst) begin
    if (apb_prst) begin
      slv_reg[0] <= 32'h0;
      slv_reg[1] <= 32'h0;
      slv_reg[2] <= 32'h0000_1234;
      slv_reg[3] <= 32'hDEAD_BEEF;
      for (int i = 0; i < NSLV; i++) wcnt[i] <= 0;
    end else begin
      for (int i = 0; i < NSLV; i++) begin
        if (apb_psel[i] && apb_penable && !apb_pready[i]) wcnt[i] <= wcnt[i] + 1;
        else if (!apb_psel[i]) wcnt[i] <= 0;
        if (apb_psel[i] && apb_penable && apb_pready[i] && apb_pwrite)
          slv_reg[i] <= apb_pwdata;
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer plus bus-wide invariants, sampled mid-cycle
  always @(negedge apb_pclk) begin : mon
    exp_t e;
    if (!apb_prst) begin
      check_output("psel_onehot", 32'($countones(apb_psel) <= 1), 32'd1);
      check_output("penable_needs_psel", 32'(apb_penable && (apb_psel == '0)), 32'd0);
      if (cpu_resp_valid) begin
        if (sb.size() == 0) begin
          check_output("resp_expected", 32'(cpu_resp_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check_output("resp_rdata", cpu_rdata, e.rdata);
          check_output("resp_err", 32'(cpu_err), 32'(e.err));
          check_output("resp_cycle", cyc, e.cyc);
          check_output("resp_psel_low", 32'(apb_psel), 32'd0);
        end
      end
    end
  end

  // Drive one request, wait until accepted; n is the accept cycle
  task automatic apply_stimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err, input int lat,
                                input bit expect_resp, output int n);
    int ok;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge apb_pclk);
      if (cpu_ready) begin
        ok = 1;
        break;
      end
    end
    check_output("accept", ok, 1);
    n = cyc;
    if (expect_resp) sb.push_back('{exp_rdata, exp_err, cyc + lat});
    @(posedge apb_pclk);
    #1;
    cpu_req = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge apb_pclk);
    check_output("resp_pending", sb.size(), 0);
    sb.delete();
    @(posedge apb_pclk);
    #1;
  endtask

  initial begin
    int n, n2, acc;
    apb_prst  = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      wait_cfg[i] = 0;
      err_cfg[i]  = 1'b0;
      hang[i]     = 1'b0;
    end

    repeat (3) @(negedge apb_pclk);
    check_output("rst_ready", 32'(cpu_ready), 32'd1);
    check_output("rst_resp_valid", 32'(cpu_resp_valid), 32'd0);
    check_output("rst_rdata", cpu_rdata, 32'd0);
    check_output("rst_err", 32'(cpu_err), 32'd0);
    check_output("rst_psel", 32'(apb_psel), 32'd0);
    check_output("rst_penable", 32'(apb_penable), 32'd0);
    check_output("rst_pwrite", 32'(apb_pwrite), 32'd0);
    check_output("rst_paddr", apb_paddr, 32'd0);
    check_output("rst_pwdata", apb_pwdata, 32'd0);
    apb_prst = 1'b0;
    @(posedge apb_pclk);
    #1;

    // Zero-wait write to slave 1 with phase checks, then read it back
    apply_stimulus(1'b1, 32'hBF00_1044, 32'hA5A5_0001, 32'h0, 1'b0, 3, 1'b1, n);
    @(negedge apb_pclk);
    check_output("wr_setup_psel", 32'(apb_psel), 32'b0010);
    check_output("wr_setup_penable", 32'(apb_penable), 32'd0);
    check_output("wr_setup_paddr", apb_paddr, 32'hBF00_1044);
    check_output("wr_setup_pwrite", 32'(apb_pwrite), 32'd1);
    check_output("wr_setup_pwdata", apb_pwdata, 32'hA5A5_0001);
    @(negedge apb_pclk);
    check_output("wr_access_psel", 32'(apb_psel), 32'b0010);
    check_output("wr_access_penable", 32'(apb_penable), 32'd1);
    wait_idle();
    check_output("wr_slave_reg", slv_reg[1], 32'hA5A5_0001);
    check_output("wr_paddr_held", apb_paddr, 32'hBF00_1044);
    apply_stimulus(1'b0, 32'hBF00_1044, 32'h0, 32'hA5A5_0001, 1'b0, 3, 1'b1, n);
    wait_idle();

    // Three wait states; the pready cycle coincides with the timeout limit
    wait_cfg[2] = 3;
    apply_stimulus(1'b0, 32'hBF00_2048, 32'h0, 32'h0000_1234, 1'b0, 6, 1'b1, n);
    wait_idle();

    // Slave error still returns its read data
    err_cfg[3] = 1'b1;
    apply_stimulus(1'b0, 32'hBF00_3000, 32'h0, 32'hDEAD_BEEF, 1'b1, 3, 1'b1, n);
    wait_idle();
    err_cfg[3] = 1'b0;

    // Decode miss: immediate error, no bus activity
    apply_stimulus(1'b0, 32'h1F00_0040, 32'h0, 32'h0, 1'b1, 1, 1'b1, n);
    @(negedge apb_pclk);
    check_output("miss_psel", 32'(apb_psel), 32'd0);
    wait_idle();

    // Hung slave: four ACCESS cycles then a timeout error
    hang[3] = 1'b1;
    apply_stimulus(1'b0, 32'hBF00_3004, 32'h0, 32'h0, 1'b1, 6, 1'b1, n);
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge apb_pclk);
      if (cpu_resp_valid) break;
      if (apb_penable) acc++;
    end
    check_output("to_access_cycles", acc, 4);
    check_output("to_resp_psel", 32'(apb_psel), 32'd0);
    @(negedge apb_pclk);
    check_output("to_ready_after", 32'(cpu_ready), 32'd1);
    wait_idle();
    hang[3] = 1'b0;

    // Reset during a waited read aborts without a response
    apply_stimulus(1'b0, 32'hBF00_2048, 32'h0, 32'h0, 1'b0, 0, 1'b0, n);
    @(negedge apb_pclk);
    @(negedge apb_pclk);
    check_output("pre_rst_penable", 32'(apb_penable), 32'd1);
    #1 apb_prst = 1'b1;
    #1;
    check_output("mid_rst_psel", 32'(apb_psel), 32'd0);
    check_output("mid_rst_penable", 32'(apb_penable), 32'd0);
    repeat (2) @(negedge apb_pclk);
    apb_prst = 1'b0;
    @(negedge apb_pclk);
    check_output("post_rst_ready", 32'(cpu_ready), 32'd1);
    @(posedge apb_pclk);
    #1;

    // Back-to-back GPIO write/read: four-cycle turnaround
    apply_stimulus(1'b1, 32'hBF00_0010, 32'h5A5A_00FF, 32'h0, 1'b0, 3, 1'b1, n);
    apply_stimulus(1'b0, 32'hBF00_0010, 32'h0, 32'h5A5A_00FF, 1'b0, 3, 1'b1, n2);
    check_output("turnaround", n2 - n, 4);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
